// File: rtl/ieeedrv_pkg.sv
// rtl/ieeedrv_pkg.sv - shared types and disk geometry helpers for the IEEE drive track arbiter
package ieeedrv_pkg;

    typedef enum logic [1:0] {ACT_NONE, ACT_WRITE, ACT_INIT, ACT_READ} act_e;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DONE} state_e;

    localparam logic [7:0] NO_TRACK = 8'hFF;

    // Start-sector tables expressed per zone: the value for t is the number of
    // sectors in tracks 1..t, i.e. the first sector of track t+1.
    function automatic logic [12:0] start_4040(input logic [7:0] t);
        int unsigned u;
        int unsigned s;
        u = {24'd0, t};
        if (u <= 17)      s = 21 * u;
        else if (u <= 24) s = 357 + 19 * (u - 17);
        else if (u <= 30) s = 490 + 18 * (u - 24);
        else              s = 598 + 17 * (u - 30);
        return 13'(s);
    endfunction

    function automatic int unsigned side_8250(input int unsigned u);
        if (u <= 39)      return 29 * u;
        else if (u <= 53) return 1131 + 27 * (u - 39);
        else if (u <= 64) return 1509 + 25 * (u - 53);
        else              return 1784 + 23 * (u - 64);
    endfunction

    // Second side repeats the first side's zones after 2083 sectors.
    function automatic logic [12:0] start_8250(input logic [7:0] t);
        int unsigned u;
        int unsigned s;
        u = {24'd0, t};
        s = (u <= 77) ? side_8250(u) : 2083 + side_8250(u - 77);
        return 13'(s);
    endfunction

    function automatic logic [12:0] start_sector(input logic dtype, input logic [7:0] t);
        return dtype ? start_4040(t) : start_8250(t);
    endfunction

    function automatic logic track_valid(input logic dtype, input logic [7:0] t);
        return (t >= 8'd1) && (t <= (dtype ? 8'd40 : 8'd154));
    endfunction

    function automatic logic [7:0] init_track(input logic dtype);
        return dtype ? 8'd18 : 8'd39;
    endfunction

endpackage

// File: rtl/ieeedrv_sync.sv
// rtl/ieeedrv_sync.sv - two-flop synchroniser for asynchronous level inputs
module ieeedrv_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ieeedrv_track_arb.sv
// rtl/ieeedrv_track_arb.sv - per-drive track buffers arbitrated round-robin onto one SD block channel
module ieeedrv_track_arb
    import ieeedrv_pkg::*;
#(
    parameter int NDRV   = 2,
    parameter int SETTLE = 64,
    parameter int DW     = (NDRV > 1) ? $clog2(NDRV) : 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              drv_type,
    input  logic [NDRV-1:0]   mounted,
    input  logic [NDRV*8-1:0] track,
    input  logic [NDRV-1:0]   dirty,
    input  logic [NDRV-1:0]   flush,
    output logic [31:0]       sd_lba,
    output logic [5:0]        sd_blk_cnt,
    output logic [DW-1:0]     sd_drv,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    output logic [NDRV*8-1:0] ltrack,
    output logic [NDRV-1:0]   busy
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE);

    logic [NDRV-1:0] m_sync, old_mounted, m_rise, m_fall;
    logic [NDRV-1:0] dirty_r, init_pend, flush_pend;
    logic [7:0]      trk      [NDRV];
    logic [7:0]      ltrack_r [NDRV];
    logic [7:0]      track_q  [NDRV];
    logic [CW-1:0]   settle   [NDRV];
    act_e            need     [NDRV];

    state_e          state, state_nx;
    logic [DW-1:0]   rr_ptr, gnt_drv, cand;
    logic [DW:0]     scan;
    logic            gnt_valid, dirty_again;
    act_e            gnt_act, g_act;
    logic [7:0]      gnt_track, g_track;
    logic [12:0]     lba_start, lba_end;

    ieeedrv_sync #(.W(NDRV)) u_mount_sync (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .d       (mounted),
        .q       (m_sync)
    );

    assign m_rise = m_sync & ~old_mounted;
    assign m_fall = ~m_sync & old_mounted;

    for (genvar g = 0; g < NDRV; g++) begin : g_drv
        assign trk[g]            = track[g*8 +: 8];
        assign ltrack[g*8 +: 8]  = ltrack_r[g];
    end

    // The track_q match keeps a freshly changed track from borrowing the old settle count.
    always_comb begin
        for (int d = 0; d < NDRV; d++) begin
            need[d] = ACT_NONE;
            if (dirty_r[d] && ltrack_r[d] != NO_TRACK && (flush_pend[d] || trk[d] != ltrack_r[d]))
                need[d] = ACT_WRITE;
            else if (init_pend[d])
                need[d] = ACT_INIT;
            else if (m_sync[d] && track_valid(drv_type, trk[d]) && trk[d] != ltrack_r[d] &&
                     settle[d] == SETTLE_MAX && trk[d] == track_q[d])
                need[d] = ACT_READ;
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_drv   = '0;
        gnt_act   = ACT_NONE;
        scan      = '0;
        cand      = '0;
        for (int i = 1; i <= NDRV; i++) begin
            scan = {1'b0, rr_ptr} + (DW+1)'(i);
            if (scan >= (DW+1)'(NDRV))
                scan = scan - (DW+1)'(NDRV);
            cand = scan[DW-1:0];
            if (!gnt_valid && need[cand] != ACT_NONE) begin
                gnt_valid = 1'b1;
                gnt_drv   = cand;
                gnt_act   = need[cand];
            end
        end
        case (gnt_act)
            ACT_WRITE: gnt_track = ltrack_r[gnt_drv];
            ACT_INIT:  gnt_track = init_track(drv_type);
            default:   gnt_track = trk[gnt_drv];
        endcase
        lba_start = start_sector(drv_type, gnt_track - 8'd1);
        lba_end   = start_sector(drv_type, gnt_track);
    end

    always_comb begin
        state_nx = state;
        sd_rd    = 1'b0;
        sd_wr    = 1'b0;
        case (state)
            ST_IDLE: if (gnt_valid) state_nx = ST_REQ;
            ST_REQ: begin
                sd_rd = (g_act != ACT_WRITE);
                sd_wr = (g_act == ACT_WRITE);
                if (sd_ack) state_nx = ST_XFER;
            end
            ST_XFER: if (!sd_ack) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sd_lba      <= '0;
            sd_blk_cnt  <= '0;
            sd_drv      <= '0;
            g_act       <= ACT_NONE;
            g_track     <= NO_TRACK;
            rr_ptr      <= DW'(NDRV - 1);
            dirty_again <= 1'b0;
        end else begin
            if (state == ST_IDLE && gnt_valid) begin
                sd_lba      <= {19'd0, lba_start};
                sd_blk_cnt  <= 6'(lba_end - lba_start - 13'd1);
                sd_drv      <= gnt_drv;
                g_act       <= gnt_act;
                g_track     <= gnt_track;
                dirty_again <= 1'b0;
            end
            if ((state == ST_REQ || state == ST_XFER) && dirty[sd_drv] && m_sync[sd_drv])
                dirty_again <= 1'b1;
            if (state == ST_DONE)
                rr_ptr <= sd_drv;
        end
    end

    // Later assignments win: mount edges override completion, pulses override write-back clear.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_mounted <= '0;
            dirty_r     <= '0;
            init_pend   <= '0;
            flush_pend  <= '0;
            busy        <= '0;
            for (int d = 0; d < NDRV; d++) begin
                ltrack_r[d] <= NO_TRACK;
                track_q[d]  <= '0;
                settle[d]   <= '0;
            end
        end else begin
            old_mounted <= m_sync;
            for (int d = 0; d < NDRV; d++) begin
                track_q[d] <= trk[d];
                if (trk[d] != track_q[d])
                    settle[d] <= '0;
                else if (ce && settle[d] != SETTLE_MAX)
                    settle[d] <= settle[d] + 1'b1;

                if (state == ST_DONE && sd_drv == DW'(d)) begin
                    busy[d] <= 1'b0;
                    if (g_act == ACT_WRITE) begin
                        if (!dirty_again) dirty_r[d] <= 1'b0;
                        flush_pend[d] <= 1'b0;
                    end else begin
                        ltrack_r[d]  <= m_sync[d] ? g_track : NO_TRACK;
                        init_pend[d] <= 1'b0;
                    end
                end
                if (state == ST_IDLE && gnt_valid && gnt_drv == DW'(d))
                    busy[d] <= 1'b1;

                if (m_sync[d]) begin
                    if (dirty[d]) dirty_r[d]    <= 1'b1;
                    if (flush[d]) flush_pend[d] <= 1'b1;
                end
                if (m_rise[d]) begin
                    init_pend[d] <= 1'b1;
                    dirty_r[d]   <= 1'b0;
                end
                if (m_fall[d]) begin
                    dirty_r[d]    <= 1'b0;
                    init_pend[d]  <= 1'b0;
                    flush_pend[d] <= 1'b0;
                    ltrack_r[d]   <= NO_TRACK;
                end
            end
        end
    end

endmodule

// File: tb/tb_ieeedrv_track_arb.sv
// tb/tb_ieeedrv_track_arb.sv - directed self-checking bench for ieeedrv_track_arb
module tb_ieeedrv_track_arb;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ce       = 1'b1;
    logic        drv_type = 1'b1;
    logic        sd_ack   = 1'b0;
    logic [1:0]  mounted  = 2'b00;
    logic [1:0]  dirty    = 2'b00;
    logic [1:0]  flush    = 2'b00;
    logic [15:0] track    = 16'd0;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic [0:0]  sd_drv;
    logic        sd_rd, sd_wr;
    logic [15:0] ltrack;
    logic [1:0]  busy;

    int checks   = 0;
    int failures = 0;

    ieeedrv_track_arb #(.NDRV(2), .SETTLE(4), .DW(1)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce         (ce),
        .drv_type   (drv_type),
        .mounted    (mounted),
        .track      (track),
        .dirty      (dirty),
        .flush      (flush),
        .sd_lba     (sd_lba),
        .sd_blk_cnt (sd_blk_cnt),
        .sd_drv     (sd_drv),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack),
        .ltrack     (ltrack),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!(sd_rd || sd_wr) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk(32'(n < 100), 32'd1, {tag, ".timeout"});
    endtask

    task automatic no_req(input int n, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr) seen = 1'b1;
        end
        chk(32'(seen), 32'd0, tag);
    endtask

    task automatic serve(input int drv, input logic wr, input int lba, input int cnt,
                         input logic redirty, input string tag);
        wait_req(tag);
        chk(32'(sd_wr), 32'(wr), {tag, ".wr"});
        chk(32'(sd_rd), 32'(!wr), {tag, ".rd"});
        chk(32'(sd_drv), drv, {tag, ".drv"});
        chk(sd_lba, lba, {tag, ".lba"});
        chk(32'(sd_blk_cnt), cnt, {tag, ".blk_cnt"});
        chk(32'(busy[drv]), 32'd1, {tag, ".busy_req"});
        sd_ack = 1'b1;
        @(negedge clk_sys);
        chk(32'(sd_rd | sd_wr), 32'd0, {tag, ".req_drop"});
        if (redirty) begin
            dirty[drv] = 1'b1;
            @(negedge clk_sys);
            dirty[drv] = 1'b0;
        end else begin
            @(negedge clk_sys);
        end
        sd_ack = 1'b0;
        @(negedge clk_sys);
        chk(32'(busy[drv]), 32'd1, {tag, ".busy_done"});
        @(negedge clk_sys);
        chk(32'(busy[drv]), 32'd0, {tag, ".busy_clr"});
    endtask

    initial begin
        cyc(3);
        chk(32'(sd_rd), 32'd0, "rst.rd");
        chk(32'(sd_wr), 32'd0, "rst.wr");
        chk(sd_lba, 32'd0, "rst.lba");
        chk(32'(sd_blk_cnt), 32'd0, "rst.blk_cnt");
        chk(32'(sd_drv), 32'd0, "rst.drv");
        chk(32'(busy), 32'd0, "rst.busy");
        chk(32'(ltrack), 32'hFFFF, "rst.ltrack");

        // 4040 mount: init read of track 18
        reset_n    = 1'b1;
        track[7:0] = 8'd18;
        mounted[0] = 1'b1;
        serve(0, 1'b0, 357, 18, 1'b0, "init4040");
        chk(32'(ltrack), 32'hFF12, "init4040.ltrack");
        no_req(12, "init4040.quiet");

        // dirty buffer, then move to track 1: write back 18, then read 1
        dirty[0] = 1'b1; cyc(1); dirty[0] = 1'b0;
        no_req(3, "dirty.no_move");
        track[7:0] = 8'd1;
        serve(0, 1'b1, 357, 18, 1'b0, "wb18");
        serve(0, 1'b0, 0, 20, 1'b0, "rd1");
        chk(32'(ltrack[7:0]), 32'd1, "rd1.ltrack");

        // settle: read must wait for SETTLE ce ticks of a stable track
        track[7:0] = 8'd2;
        no_req(5, "settle.early");
        @(negedge clk_sys);
        chk(32'(sd_rd), 32'd1, "settle.on_time");
        serve(0, 1'b0, 21, 20, 1'b0, "rd2");
        chk(32'(ltrack[7:0]), 32'd2, "rd2.ltrack");

        // dirty during write-back keeps the buffer dirty; dirty+flush forces a second write
        dirty[0] = 1'b1; cyc(1); dirty[0] = 1'b0;
        no_req(4, "dirty_only.quiet");
        flush[0] = 1'b1; cyc(1); flush[0] = 1'b0;
        serve(0, 1'b1, 21, 20, 1'b1, "flush_wr1");
        no_req(10, "redirty.no_auto_wr");
        dirty[0] = 1'b1; flush[0] = 1'b1; cyc(1); dirty[0] = 1'b0; flush[0] = 1'b0;
        serve(0, 1'b1, 21, 20, 1'b0, "flush_wr2");
        no_req(10, "flush.clean");

        // unmount: buffer dropped, no write
        mounted[0] = 1'b0;
        no_req(6, "unmount.quiet");
        chk(32'(ltrack), 32'hFFFF, "unmount.ltrack");

        // 8250 geometry: init at 39, then last track 154, then invalid tracks
        drv_type   = 1'b0;
        track[7:0] = 8'd154;
        mounted[0] = 1'b1;
        serve(0, 1'b0, 1102, 28, 1'b0, "init8250");
        serve(0, 1'b0, 4143, 22, 1'b0, "rd154");
        chk(32'(ltrack[7:0]), 32'd154, "rd154.ltrack");
        track[7:0] = 8'd155;
        no_req(12, "t155.quiet");
        chk(32'(ltrack[7:0]), 32'd154, "t155.ltrack");
        chk(32'(busy), 32'd0, "t155.busy");
        track[7:0] = 8'd0;
        no_req(12, "t0.quiet");
        chk(32'(ltrack[7:0]), 32'd154, "t0.ltrack");
        chk(32'(busy), 32'd0, "t0.busy");

        // reset during a pending request, then both drives re-init in order
        track[7:0] = 8'd100;
        wait_req("rd100");
        chk(sd_lba, 32'd2721, "rd100.lba");
        chk(32'(sd_blk_cnt), 32'd28, "rd100.blk_cnt");
        reset_n = 1'b0;
        #1;
        chk(32'(sd_rd), 32'd0, "rst_mid.rd");
        chk(32'(sd_wr), 32'd0, "rst_mid.wr");
        chk(32'(busy), 32'd0, "rst_mid.busy");
        chk(32'(ltrack), 32'hFFFF, "rst_mid.ltrack");
        track   = {8'd39, 8'd39};
        mounted = 2'b11;
        cyc(2);
        reset_n = 1'b1;
        serve(0, 1'b0, 1102, 28, 1'b0, "reinit0");
        serve(1, 1'b0, 1102, 28, 1'b0, "reinit1");
        chk(32'(ltrack), 32'h2727, "reinit.ltrack");
        no_req(8, "reinit.quiet");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
